// File: rtl/clause_loader.sv
// Collects a stream of 2-bit literal codes into a clause buffer and writes one
// clause row per pass step, filling rows 0..NUM_CLAUSES-1 in order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; outputs quiet, cidx/err hold
// COLLECT | accepting literals into the buffer until lit_last_i
// WRITE   | one-cycle row strobe wr_o = 1<<cidx with lit_o = buffer
// DONE    | one-cycle done_o pulse after the final row, then IDLE
module clause_loader #(
    parameter int NUM_LITS    = 8,
    parameter int NUM_CLAUSES = 8,
    parameter int CIDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    lit_valid_i,
    input  logic [1:0]              lit_data_i,
    input  logic                    lit_last_i,
    output logic                    lit_ready_o,
    output logic [NUM_CLAUSES-1:0]  wr_o,
    output logic [NUM_LITS*2-1:0]   lit_o,
    output logic [CIDX_W-1:0]       cidx_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int CNT_W = $clog2(NUM_LITS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [NUM_LITS*2-1:0]   lit_buf;
    logic [CNT_W-1:0]        slot_cnt;
    logic [CIDX_W-1:0]       cidx;
    logic                    err;
    logic                    accept;
    logic                    last_row;
    logic [1:0]              store_code;

    assign accept     = lit_valid_i && lit_ready_o;
    assign last_row   = (cidx == CIDX_W'(NUM_CLAUSES - 1));
    assign store_code = (lit_data_i == 2'b11) ? 2'b00 : lit_data_i;

    assign lit_o  = lit_buf;
    assign cidx_o = cidx;
    assign err_o  = err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lit_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        wr_o        = '0;
        unique case (state)
            IDLE: begin
                if (start_i) state_nxt = COLLECT;
            end
            COLLECT: begin
                lit_ready_o = 1'b1;
                busy_o      = 1'b1;
                if (lit_valid_i && lit_last_i) state_nxt = WRITE;
            end
            WRITE: begin
                busy_o    = 1'b1;
                wr_o      = NUM_CLAUSES'(1) << cidx;
                state_nxt = last_row ? DONE : COLLECT;
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slot count saturates at NUM_LITS so overflow literals are dropped, not wrapped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lit_buf  <= '0;
            slot_cnt <= '0;
            cidx     <= '0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        lit_buf  <= '0;
                        slot_cnt <= '0;
                        cidx     <= '0;
                        err      <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (slot_cnt == CNT_W'(NUM_LITS)) begin
                            err <= 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_LITS; i++) begin
                                if (slot_cnt == CNT_W'(i)) lit_buf[2*i +: 2] <= store_code;
                            end
                            slot_cnt <= slot_cnt + CNT_W'(1);
                            if (lit_data_i == 2'b11) err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    lit_buf  <= '0;
                    slot_cnt <= '0;
                    if (!last_row) cidx <= cidx + CIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_loader.sv
// Directed self-checking bench for clause_loader with the default 8x8 geometry.
module tb_clause_loader;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        lit_valid_i;
    logic [1:0]  lit_data_i;
    logic        lit_last_i;
    logic        lit_ready_o;
    logic [7:0]  wr_o;
    logic [15:0] lit_o;
    logic [2:0]  cidx_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    clause_loader #(.NUM_LITS(8), .NUM_CLAUSES(8), .CIDX_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .lit_valid_i (lit_valid_i),
        .lit_data_i  (lit_data_i),
        .lit_last_i  (lit_last_i),
        .lit_ready_o (lit_ready_o),
        .wr_o        (wr_o),
        .lit_o       (lit_o),
        .cidx_o      (cidx_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code, input logic last);
        lit_valid_i = 1'b1;
        lit_data_i  = code;
        lit_last_i  = last;
        step();
        lit_valid_i = 1'b0;
        lit_last_i  = 1'b0;
        lit_data_i  = 2'b00;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        start_i     = 1'b0;
        lit_valid_i = 1'b0;
        lit_data_i  = 2'b00;
        lit_last_i  = 1'b0;
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_wr", wr_o, 0);
        chk("reset_ready", lit_ready_o, 0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_busy", busy_o, 0);
        chk("idle_ready", lit_ready_o, 0);

        // first clause {10,01,10 last}
        do_start();
        chk("collect_ready", lit_ready_o, 1);
        chk("collect_busy", busy_o, 1);
        chk("collect_cidx", cidx_o, 0);
        send(2'b10, 1'b0);
        chk("no_wr_mid_clause", wr_o, 8'h00);
        send(2'b01, 1'b0);
        send(2'b10, 1'b1);
        chk("c0_wr", wr_o, 8'h01);
        chk("c0_lit", lit_o, 16'h0026);
        chk("c0_ready_low", lit_ready_o, 0);
        step();
        chk("c0_after_wr", wr_o, 8'h00);
        chk("c0_after_cidx", cidx_o, 1);
        chk("c0_after_lit", lit_o, 16'h0000);

        // three literals buffered, then ignored start, then async reset
        send(2'b10, 1'b0);
        send(2'b10, 1'b0);
        send(2'b10, 1'b0);
        chk("partial_lit", lit_o, 16'h002A);
        do_start();
        chk("start_in_collect_cidx", cidx_o, 1);
        chk("start_in_collect_lit", lit_o, 16'h002A);
        chk("start_in_collect_busy", busy_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_lit", lit_o, 0);
        chk("async_rst_cidx", cidx_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_ready", lit_ready_o, 0);
        chk("async_rst_err", err_o, 0);
        #2 rst = 1'b1;
        lit_valid_i = 1'b1;
        lit_data_i  = 2'b10;
        lit_last_i  = 1'b1;
        step();
        chk("post_rst_wr", wr_o, 0);
        step();
        chk("post_rst_idle", busy_o, 0);
        chk("post_rst_wr2", wr_o, 0);

        // 8 back-to-back single-literal clauses with valid held high
        do_start();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("b2b_wr", wr_o, 32'(8'h01 << i));
            chk("b2b_lit", lit_o, 16'h0002);
            chk("b2b_ready_low", lit_ready_o, 0);
            step();
            if (i < 7) begin
                chk("b2b_cidx", cidx_o, 32'(i + 1));
                chk("b2b_wr_off", wr_o, 0);
                chk("b2b_ready", lit_ready_o, 1);
            end else begin
                chk("b2b_done", done_o, 1);
                chk("b2b_done_busy", busy_o, 1);
                chk("b2b_done_wr", wr_o, 0);
            end
        end
        lit_valid_i = 1'b0;
        lit_last_i  = 1'b0;
        do_start();
        chk("start_in_done_busy", busy_o, 0);
        chk("start_in_done_cidx", cidx_o, 7);
        chk("after_done_pulse", done_o, 0);
        step();
        chk("stays_idle", busy_o, 0);

        // overflow: ten 01 literals, last on the tenth
        do_start();
        for (int i = 0; i < 9; i++) begin
            send(2'b01, 1'b0);
            if (i == 7) chk("ovf_err_before", err_o, 0);
        end
        chk("ovf_err_set", err_o, 1);
        send(2'b01, 1'b1);
        chk("ovf_wr", wr_o, 8'h01);
        chk("ovf_lit", lit_o, 16'h5555);
        for (int i = 1; i < 8; i++) begin
            step();
            send(2'b00, 1'b1);
            chk("ovf_fill_wr", wr_o, 32'(8'h01 << i));
            chk("ovf_fill_lit", lit_o, 16'h0000);
        end
        step();
        chk("ovf_done", done_o, 1);
        chk("ovf_err_done", err_o, 1);
        step();
        chk("ovf_err_idle", err_o, 1);
        do_start();
        chk("err_cleared", err_o, 0);
        chk("restart_cidx", cidx_o, 0);

        // illegal code in slot 2
        send(2'b10, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b1);
        chk("ill_wr", wr_o, 8'h01);
        chk("ill_lit", lit_o, 16'h000A);
        chk("ill_err", err_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
